game_control_mp: RTL and testbench

Parametrised multi-player successor to the single-player game controller FSM.
- Sequences START -> ROLL -> CHOOSE -> END across NUM_PLAYERS players, with round-robin turn passing, player elimination, a turn limit that ends in a draw, and restart from END.
- Sits between the Start/Roll/Choose/End display modules and their demux.
- Consumes the shared button/done strobe and the Choose module's result code.

---
 rtl/game_control_mp.sv | 225 ++++++++++++++++++++++
 tb/tb_game_control_mp.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/game_control_mp.sv
`default_nettype none
// ============================================================================
// Module   : game_control_mp
// Brief    : Multi-player game sequencer. Steps START -> ROLL -> CHOOSE -> END
//            on rising edges of a shared strobe, passes turns round-robin,
//            handles player elimination, a turn limit that ends in a draw,
//            and restart from END.
// Revision : 1.0 - initial release
// ============================================================================
module game_control_mp #(
    parameter int NUM_PLAYERS = 2,
    parameter int TURN_W      = 4,
    parameter int MAX_TURNS   = 15,
    parameter int PLAYER_W    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pulse_i,
    input  logic [1:0]             choose_result,
    output logic                   pulse_o,
    output logic [1:0]             state,
    output logic [TURN_W-1:0]      turns,
    output logic [PLAYER_W-1:0]    player,
    output logic [NUM_PLAYERS-1:0] active,
    output logic                   won,
    output logic                   draw,
    output logic [PLAYER_W-1:0]    winner
);

    // State encoding doubles as the demux select on the state output.
    localparam logic [1:0] c_ST_START  = 2'b00;
    localparam logic [1:0] c_ST_ROLL   = 2'b01;
    localparam logic [1:0] c_ST_CHOOSE = 2'b10;
    localparam logic [1:0] c_ST_END    = 2'b11;

    localparam logic [1:0] c_RES_CONTINUE  = 2'b00;
    localparam logic [1:0] c_RES_ELIMINATE = 2'b01;
    localparam logic [1:0] c_RES_WON       = 2'b10;
    localparam logic [1:0] c_RES_PASS      = 2'b11;

    localparam logic [TURN_W-1:0]      c_MAX_TURNS = TURN_W'(MAX_TURNS);
    localparam logic [TURN_W-1:0]      c_TURN_ONE  = TURN_W'(1);
    localparam logic [NUM_PLAYERS-1:0] c_ALL_ON    = {NUM_PLAYERS{1'b1}};

    logic [1:0]             r_state;
    logic [1:0]             w_state_nx;
    logic                   r_pulse_q;
    logic                   r_pulse_o;
    logic [TURN_W-1:0]      r_turns,  w_turns_nx;
    logic [PLAYER_W-1:0]    r_player, w_player_nx;
    logic [NUM_PLAYERS-1:0] r_active, w_active_nx;
    logic                   r_won,    w_won_nx;
    logic                   r_draw,   w_draw_nx;
    logic [PLAYER_W-1:0]    r_winner, w_winner_nx;
    logic                   w_pulse_o_nx;

    logic                   w_ev;
    logic                   w_at_limit;
    logic [NUM_PLAYERS-1:0] w_active_elim;
    logic [NUM_PLAYERS-1:0] w_mask;
    logic [PLAYER_W-1:0]    w_next;
    logic                   w_found;
    logic [PLAYER_W-1:0]    w_idx;
    logic [3:0]             w_remain_cnt;
    logic [PLAYER_W-1:0]    w_remain_idx;

    assign w_ev       = pulse_i & ~r_pulse_q;
    assign w_at_limit = (r_turns == c_MAX_TURNS);

    // Survivor mask, survivor count and lowest survivor if the current player is removed.
    always_comb begin
        w_active_elim = r_active;
        w_remain_cnt  = 4'd0;
        w_remain_idx  = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (PLAYER_W'(i) == r_player) begin
                w_active_elim[i] = 1'b0;
            end
        end
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (w_active_elim[i]) begin
                w_remain_cnt = w_remain_cnt + 4'd1;
                w_remain_idx = PLAYER_W'(i);
            end
        end
    end

    // Round-robin search for the next active player after the current one.
    always_comb begin
        w_mask  = (choose_result == c_RES_ELIMINATE) ? w_active_elim : r_active;
        w_next  = r_player;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_PLAYERS; k++) begin
            w_idx = PLAYER_W'((int'(r_player) + k) % NUM_PLAYERS);
            if (!w_found && w_mask[w_idx]) begin
                w_next  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // Next-state and next-datapath decisions, one event per clock.
    always_comb begin
        w_state_nx  = r_state;
        w_turns_nx  = r_turns;
        w_player_nx = r_player;
        w_active_nx = r_active;
        w_won_nx    = r_won;
        w_draw_nx   = r_draw;
        w_winner_nx = r_winner;
        if (w_ev) begin
            case (r_state)
                c_ST_START: begin
                    w_state_nx  = c_ST_ROLL;
                    w_turns_nx  = c_TURN_ONE;
                    w_player_nx = '0;
                    w_active_nx = c_ALL_ON;
                    w_won_nx    = 1'b0;
                    w_draw_nx   = 1'b0;
                    w_winner_nx = '0;
                end
                c_ST_ROLL: begin
                    w_state_nx = c_ST_CHOOSE;
                end
                c_ST_CHOOSE: begin
                    case (choose_result)
                        c_RES_WON: begin
                            w_state_nx  = c_ST_END;
                            w_won_nx    = 1'b1;
                            w_winner_nx = r_player;
                        end
                        c_RES_CONTINUE: begin
                            if (w_at_limit) begin
                                w_state_nx = c_ST_END;
                                w_draw_nx  = 1'b1;
                            end else begin
                                w_state_nx = c_ST_ROLL;
                                w_turns_nx = r_turns + c_TURN_ONE;
                            end
                        end
                        c_RES_PASS: begin
                            if (w_at_limit) begin
                                w_state_nx = c_ST_END;
                                w_draw_nx  = 1'b1;
                            end else begin
                                w_state_nx  = c_ST_ROLL;
                                w_turns_nx  = r_turns + c_TURN_ONE;
                                w_player_nx = w_next;
                            end
                        end
                        default: begin
                            w_active_nx = w_active_elim;
                            if (w_remain_cnt == 4'd0) begin
                                w_state_nx = c_ST_END;
                            end else if (w_remain_cnt == 4'd1) begin
                                w_state_nx  = c_ST_END;
                                w_won_nx    = 1'b1;
                                w_winner_nx = w_remain_idx;
                            end else if (w_at_limit) begin
                                w_state_nx = c_ST_END;
                                w_draw_nx  = 1'b1;
                            end else begin
                                w_state_nx  = c_ST_ROLL;
                                w_turns_nx  = r_turns + c_TURN_ONE;
                                w_player_nx = w_next;
                            end
                        end
                    endcase
                end
                default: begin
                    // END: results stay visible until the next game starts.
                    w_state_nx = c_ST_START;
                end
            endcase
        end
        w_pulse_o_nx = (w_state_nx == c_ST_ROLL) && (r_state != c_ST_ROLL);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_START;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Datapath registers: edge detector, turn bookkeeping and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse_q <= 1'b0;
            r_pulse_o <= 1'b0;
            r_turns   <= '0;
            r_player  <= '0;
            r_active  <= c_ALL_ON;
            r_won     <= 1'b0;
            r_draw    <= 1'b0;
            r_winner  <= '0;
        end else begin
            r_pulse_q <= pulse_i;
            r_pulse_o <= w_pulse_o_nx;
            r_turns   <= w_turns_nx;
            r_player  <= w_player_nx;
            r_active  <= w_active_nx;
            r_won     <= w_won_nx;
            r_draw    <= w_draw_nx;
            r_winner  <= w_winner_nx;
        end
    end

    // Outputs are driven straight from registers.
    always_comb begin
        state   = r_state;
        pulse_o = r_pulse_o;
        turns   = r_turns;
        player  = r_player;
        active  = r_active;
        won     = r_won;
        draw    = r_draw;
        winner  = r_winner;
    end

endmodule
`default_nettype wire

// File: tb/tb_game_control_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_control_mp
// Brief    : Directed, table-driven bench for game_control_mp with three
//            players and a four-turn limit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_control_mp;

    localparam int NP = 3;
    localparam int TW = 4;
    localparam int MT = 4;
    localparam int PW = 2;

    localparam logic [1:0] S = 2'd0, R = 2'd1, C = 2'd2, E = 2'd3;
    localparam logic [1:0] CONT = 2'd0, ELIM = 2'd1, WON = 2'd2, PASS = 2'd3;

    logic          clk;
    logic          rst_n;
    logic          pulse_i;
    logic [1:0]    choose_result;
    logic          pulse_o;
    logic [1:0]    state;
    logic [TW-1:0] turns;
    logic [PW-1:0] player;
    logic [NP-1:0] active;
    logic          won;
    logic          draw;
    logic [PW-1:0] winner;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] res;
        logic [1:0] st;
        int         tn;
        int         pl;
        logic [2:0] act;
        logic       wn;
        logic       dr;
        int         wi;
        logic       po;
    } vec_t;

    vec_t vecs[$];

    game_control_mp #(
        .NUM_PLAYERS(NP),
        .TURN_W     (TW),
        .MAX_TURNS  (MT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pulse_i      (pulse_i),
        .choose_result(choose_result),
        .pulse_o      (pulse_o),
        .state        (state),
        .turns        (turns),
        .player       (player),
        .active       (active),
        .won          (won),
        .draw         (draw),
        .winner       (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic add(input logic [1:0] res, input logic [1:0] st, input int tn, input int pl,
                       input logic [2:0] act, input logic wn, input logic dr, input int wi,
                       input logic po);
        vec_t v;
        v.res = res; v.st = st; v.tn = tn; v.pl = pl; v.act = act;
        v.wn = wn; v.dr = dr; v.wi = wi; v.po = po;
        vecs.push_back(v);
    endtask

    // One rising edge on pulse_i; returns at the negedge after the event edge.
    task automatic ev_step(input logic [1:0] res);
        @(negedge clk);
        pulse_i = 1'b1;
        choose_result = res;
        @(negedge clk);
        pulse_i = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input int tn, input int pl,
                             input logic [2:0] act, input logic wn, input logic dr, input int wi,
                             input logic po);
        check({tag, ".state"},   32'(state),   32'(st));
        check({tag, ".turns"},   32'(turns),   32'(tn));
        check({tag, ".player"},  32'(player),  32'(pl));
        check({tag, ".active"},  32'(active),  32'(act));
        check({tag, ".won"},     32'(won),     32'(wn));
        check({tag, ".draw"},    32'(draw),    32'(dr));
        check({tag, ".winner"},  32'(winner),  32'(wi));
        check({tag, ".pulse_o"}, 32'(pulse_o), 32'(po));
    endtask

    initial begin
        int po_cnt;

        //   res   st tn pl act  wn dr wi po
        // Game 1: PASS round-robin, then CONTINUE at the limit -> draw
        add(CONT, R, 1, 0, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 1, 0, 3'b111, 0, 0, 0, 0);
        add(PASS, R, 2, 1, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 2, 1, 3'b111, 0, 0, 0, 0);
        add(PASS, R, 3, 2, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 3, 2, 3'b111, 0, 0, 0, 0);
        add(PASS, R, 4, 0, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 4, 0, 3'b111, 0, 0, 0, 0);
        add(CONT, E, 4, 0, 3'b111, 0, 1, 0, 0);
        add(CONT, S, 4, 0, 3'b111, 0, 1, 0, 0);
        // Game 2: eliminations leading to a single survivor
        add(CONT, R, 1, 0, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 1, 0, 3'b111, 0, 0, 0, 0);
        add(PASS, R, 2, 1, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 2, 1, 3'b111, 0, 0, 0, 0);
        add(ELIM, R, 3, 2, 3'b101, 0, 0, 0, 1);
        add(CONT, C, 3, 2, 3'b101, 0, 0, 0, 0);
        add(PASS, R, 4, 0, 3'b101, 0, 0, 0, 1);
        add(CONT, C, 4, 0, 3'b101, 0, 0, 0, 0);
        add(ELIM, E, 4, 0, 3'b100, 1, 0, 2, 0);
        add(CONT, S, 4, 0, 3'b100, 1, 0, 2, 0);
        // Game 3: player 1 wins on turn 2; results held through START
        add(CONT, R, 1, 0, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 1, 0, 3'b111, 0, 0, 0, 0);
        add(PASS, R, 2, 1, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 2, 1, 3'b111, 0, 0, 0, 0);
        add(WON,  E, 2, 1, 3'b111, 1, 0, 1, 0);
        add(CONT, S, 2, 1, 3'b111, 1, 0, 1, 0);
        // Game 4: CONTINUE every turn -> draw after turn 4
        add(CONT, R, 1, 0, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 1, 0, 3'b111, 0, 0, 0, 0);
        add(CONT, R, 2, 0, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 2, 0, 3'b111, 0, 0, 0, 0);
        add(CONT, R, 3, 0, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 3, 0, 3'b111, 0, 0, 0, 0);
        add(CONT, R, 4, 0, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 4, 0, 3'b111, 0, 0, 0, 0);
        add(CONT, E, 4, 0, 3'b111, 0, 1, 0, 0);
        add(CONT, S, 4, 0, 3'b111, 0, 1, 0, 0);
        // Game 5: elimination at the limit with two survivors -> draw
        add(CONT, R, 1, 0, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 1, 0, 3'b111, 0, 0, 0, 0);
        add(PASS, R, 2, 1, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 2, 1, 3'b111, 0, 0, 0, 0);
        add(PASS, R, 3, 2, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 3, 2, 3'b111, 0, 0, 0, 0);
        add(PASS, R, 4, 0, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 4, 0, 3'b111, 0, 0, 0, 0);
        add(ELIM, E, 4, 0, 3'b110, 0, 1, 0, 0);
        // Game 6: walk into CHOOSE for the asynchronous reset check
        add(CONT, S, 4, 0, 3'b110, 0, 1, 0, 0);
        add(CONT, R, 1, 0, 3'b111, 0, 0, 0, 1);
        add(CONT, C, 1, 0, 3'b111, 0, 0, 0, 0);

        rst_n = 1'b0;
        pulse_i = 1'b0;
        choose_result = CONT;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("reset", S, 0, 0, 3'b111, 0, 0, 0, 0);

        // Held-high strobe in START: one transition, one pulse_o
        pulse_i = 1'b1;
        po_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (pulse_o) po_cnt++;
        end
        check("held.pulse_cnt", 32'(po_cnt), 32'd1);
        check("held.state",     32'(state),  32'(R));
        check("held.turns",     32'(turns),  32'd1);
        check("held.player",    32'(player), 32'd0);
        @(negedge clk);
        pulse_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            ev_step(vecs[i].res);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].tn, vecs[i].pl,
                      vecs[i].act, vecs[i].wn, vecs[i].dr, vecs[i].wi, vecs[i].po);
        end

        // Asynchronous reset mid-CHOOSE, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async", S, 0, 0, 3'b111, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst.idle", 32'(state), 32'(S));
        ev_step(CONT);
        check_all("post_rst", R, 1, 0, 3'b111, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
